tiny_exec_ctrl: RTL

TINY_EXEC_CTRL -- requirements
Module: tiny_exec_ctrl

---
 rtl/tiny_pkg.sv | 45 ++++
 rtl/tiny_regfile.sv | 63 ++++++
 rtl/tiny_exec_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/tiny_pkg.sv
// Shared definitions for the tiny execution controller: opcodes, instruction
// field layout, register-file geometry and the sequencer state encoding.
package tiny_pkg;

  localparam int REG_W    = 2;
  localparam int RF_DEPTH = 4;
  localparam int INSTR_W  = 9;

  localparam int OPC_LSB = 6;
  localparam int RD_LSB  = 4;
  localparam int RS1_LSB = 2;
  localparam int RS2_LSB = 0;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.opcode = w[OPC_LSB +: 3];
    d.rd     = w[RD_LSB  +: REG_W];
    d.rs1    = w[RS1_LSB +: REG_W];
    d.rs2    = w[RS2_LSB +: REG_W];
    return d;
  endfunction

endpackage

// File: rtl/tiny_regfile.sv
// 4x2-bit register file: two operand ports captured on rd_en, one write port,
// one combinational debug read. Zero-register behaviour under TINY_EXEC_ZERO_REG_EN.
// Latency: operands registered one edge after rd_en; writes visible after the edge.
module tiny_regfile
  import tiny_pkg::*;
#(
  parameter logic [REG_W-1:0] RF_INIT = 2'b00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [REG_W-1:0] rs1_addr,
  input  logic [REG_W-1:0] rs2_addr,
  output logic [REG_W-1:0] rs1_q,
  output logic [REG_W-1:0] rs2_q,
  input  logic             wr_en,
  input  logic [REG_W-1:0] wr_addr,
  input  logic [REG_W-1:0] wr_data,
  input  logic [REG_W-1:0] dbg_addr,
  output logic [REG_W-1:0] dbg_data
);

  logic [REG_W-1:0] rf      [RF_DEPTH];
  logic [REG_W-1:0] rf_view [RF_DEPTH];
  logic             wr_ok;

  // Architectural view of the array: entry 0 may be hardwired to zero.
  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) begin
      rf_view[i] = rf[i];
    end
`ifdef TINY_EXEC_ZERO_REG_EN
    rf_view[0] = '0;
`endif
  end

`ifdef TINY_EXEC_ZERO_REG_EN
  assign wr_ok = wr_en && (wr_addr != '0);
`else
  assign wr_ok = wr_en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= RF_INIT;
      end
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      if (wr_ok) begin
        rf[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rs1_q <= rf_view[rs1_addr];
        rs2_q <= rf_view[rs2_addr];
      end
    end
  end

  assign dbg_data = rf_view[dbg_addr];

endmodule

// File: rtl/tiny_exec_ctrl.sv
// Three-phase instruction sequencer (IDLE/EXEC/WB) around an external 2-bit ALU; optional TINY_EXEC_ZERO_REG_EN.
// Latency: accept at edge N, result captured at N+1, register write at N+2.
// Backpressure: instr_ready high only in IDLE, so one instruction per 3 cycles.
module tiny_exec_ctrl
  import tiny_pkg::*;
#(
  parameter logic [1:0] RF_INIT = 2'b00,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [8:0]       instr,
  output logic             instr_ready,
  output logic [2:0]       alu_opcode,
  output logic [1:0]       alu_rs1,
  output logic [1:0]       alu_rs2,
  input  logic [1:0]       alu_result,
  output logic             wb_valid,
  output logic [1:0]       wb_rd,
  output logic [1:0]       wb_data,
  input  logic [1:0]       dbg_addr,
  output logic [1:0]       dbg_data,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q;
  state_t           state_d;
  instr_t           dec;
  logic             accept;
  logic [2:0]       opcode_q;
  logic [REG_W-1:0] rd_q;
  logic [REG_W-1:0] res_q;
  logic [REG_W-1:0] op1_q;
  logic [REG_W-1:0] op2_q;
  logic [CNT_W-1:0] retired_q;

  assign dec    = decode(instr);
  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode and rd only load on acceptance, so the ALU inputs hold steady
  // outside EXEC without any extra muxing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      retired_q <= '0;
    end else begin
      if (accept) begin
        opcode_q <= dec.opcode;
        rd_q     <= dec.rd;
      end
      if (state_q == ST_EXEC) begin
        res_q <= alu_result;
      end
      if (state_q == ST_WB) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  tiny_regfile #(
    .RF_INIT (RF_INIT)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (accept),
    .rs1_addr (dec.rs1),
    .rs2_addr (dec.rs2),
    .rs1_q    (op1_q),
    .rs2_q    (op2_q),
    .wr_en    (wb_valid),
    .wr_addr  (rd_q),
    .wr_data  (res_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_opcode = opcode_q;
  assign alu_rs1    = op1_q;
  assign alu_rs2    = op2_q;
  assign wb_rd      = rd_q;
  assign wb_data    = res_q;
  assign retired    = retired_q;

endmodule
